// File: rtl/out_display_pkg.sv
// Shared definitions for the output display stage: bus width, conversion states and
// 7-segment codes ordered {g,f,e,d,c,b,a}, active-high before polarity is applied.
package out_display_pkg;

  localparam int unsigned BUS_W = 8;
  localparam int unsigned BCD_W = 10;

  typedef enum logic [1:0] {StIdle, StConv, StDone} conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/out_display_if.sv
// Bus-side connection of the output stage: the data bus and load strobe in, status and
// output-register contents back out.
interface out_display_if;
  import out_display_pkg::*;

  logic [BUS_W-1:0] bus;
  logic             Oi;
  logic             busy;
  logic [BUS_W-1:0] value;

  modport master (output bus, Oi, input busy, value);
  modport slave  (input bus, Oi, output busy, value);

endinterface

// File: rtl/out_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 8 shift-add steps after start, then a one-cycle done.
// A start while busy restarts from step 0 and the pending result is dropped.
module out_display_bin2bcd_seq
  import out_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BUS_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e state_q, state_d;
  logic [3:0]  step_q, step_d;
  // {hundreds[17:16], tens[15:12], units[11:8], binary[7:0]}
  logic [BCD_W+BUS_W-1:0] sh_q, sh_d, adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    adj = sh_q;
    if (sh_q[11:8] >= 4'd5)  adj[11:8]  = sh_q[11:8] + 4'd3;
    if (sh_q[15:12] >= 4'd5) adj[15:12] = sh_q[15:12] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sh_d    = sh_q;
    case (state_q)
      StConv: begin
        sh_d   = {adj[BCD_W+BUS_W-2:0], 1'b0};
        step_d = step_q + 4'd1;
        if (step_q == 4'd7) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d = StConv;
      step_d  = 4'd0;
      sh_d    = {{BCD_W{1'b0}}, din};
    end
  end

  assign busy = (state_q != StIdle);
  // A reload on the DONE cycle supersedes the finishing result.
  assign done = (state_q == StDone) && !start;
  assign bcd  = sh_q[BCD_W+BUS_W-1:BUS_W];

endmodule

// File: rtl/out_display.sv
// Output stage: captures the bus on Oi, converts to BCD and scans a 4-digit 7-segment display.
// Define OUT_DISPLAY_SIGNED_EN to show the register as two's complement with a minus on digit 3.
module out_display
  import out_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  out_display_if.slave  obus,
  output logic [6:0]    seg,
  output logic [3:0]    an
);

  logic [BUS_W-1:0]    value_q;
  logic [BUS_W-1:0]    conv_din;
  logic                conv_busy, conv_done;
  logic [BCD_W-1:0]    conv_bcd;
  logic [BCD_W-1:0]    disp_bcd_q;
  logic [SCAN_DIV-1:0] presc_q;
  logic [1:0]          digit_q;
  logic [3:0]          hundreds, tens, units;
  logic [6:0]          seg_raw;
  logic [3:0]          an_raw;

`ifdef OUT_DISPLAY_SIGNED_EN
  logic disp_neg_q;
  assign conv_din = obus.bus[7] ? (~obus.bus + 8'd1) : obus.bus;
`else
  assign conv_din = obus.bus;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (obus.Oi) begin
      value_q <= obus.bus;
    end
  end

  out_display_bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (obus.Oi),
    .din   (conv_din),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // The latch only moves on done, so partial BCD never reaches the segments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bcd_q <= '0;
`ifdef OUT_DISPLAY_SIGNED_EN
      disp_neg_q <= 1'b0;
`endif
    end else if (conv_done) begin
      disp_bcd_q <= conv_bcd;
`ifdef OUT_DISPLAY_SIGNED_EN
      disp_neg_q <= value_q[7];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= 2'd0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) digit_q <= digit_q + 2'd1;
    end
  end

  assign hundreds = {2'b00, disp_bcd_q[9:8]};
  assign tens     = disp_bcd_q[7:4];
  assign units    = disp_bcd_q[3:0];

  always_comb begin
    seg_raw = SEG_BLANK;
    an_raw  = 4'b0001 << digit_q;
    case (digit_q)
      2'd0: seg_raw = seg_digit(units);
      2'd1: if (hundreds != 4'd0 || tens != 4'd0) seg_raw = seg_digit(tens);
      2'd2: if (hundreds != 4'd0) seg_raw = seg_digit(hundreds);
      default: begin
`ifdef OUT_DISPLAY_SIGNED_EN
        if (disp_neg_q) seg_raw = SEG_MINUS;
`endif
      end
    endcase
  end

  assign seg        = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign an         = SEG_ACTIVE_LOW ? ~an_raw : an_raw;
  assign obus.busy  = conv_busy;
  assign obus.value = value_q;

endmodule
